// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream link plus imem write port for the boot loader.
//   in_valid/in_data  host -> loader byte stream
//   in_ready          loader -> host, byte accepted when in_valid & in_ready
//   wr_en/wr_address/wr_data  loader -> imem write port, one pulse per word
// master: host/bench side (drives the stream, observes the write port)
// slave : loader side (consumes the stream, drives the write port)
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_address, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_address, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a framed byte stream {LEN_HI, LEN_LO, 4*N data bytes, XOR checksum},
// packs data bytes big-endian into 32-bit words and writes them to imem at
// sequential word addresses starting at 0. The processor is held in reset
// (cpu_hold=1) until a complete, checksum-verified image has been written.
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-low
//   start       one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus         imem_loader_if.slave: byte stream in, imem write port out
//   cpu_hold    processor reset, low only in DONE
//   busy        loading (LEN_HI, LEN_LO, DATA, CHECK)
//   done/error  final status of the last load
//   word_count  words written in the current or last load
// All outputs are registered; status flops are loaded from the next state.
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // Largest legal image, in words. ADDR_W <= 15 keeps this inside 16 bits.
  localparam logic [15:0] LIMIT = 16'(1) << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      len_hi;     // high length byte, held until LEN_LO arrives
  logic [ADDR_W:0] len;        // image length in words (only legal values kept)
  logic [7:0]      xor_acc;    // running XOR of every frame byte so far
  logic [1:0]      byte_cnt;   // byte position within the current word
  logic [31:0]     word_reg;   // shift register, doubles as wr_data

  logic            accept;
  logic            load_go;
  logic            word_done;
  logic            last_word;
  logic            ready_nxt;
  logic [15:0]     len_rx;
  logic [ADDR_W:0] wc_inc;

  assign accept  = bus.in_valid & bus.in_ready;
  assign len_rx  = {len_hi, bus.in_data};
  assign wc_inc  = word_count + {{ADDR_W{1'b0}}, 1'b1};
  assign bus.wr_data = word_reg;

  // word_count is always current when a word completes: a word takes at least
  // four accepts, and the previous write pulse ends on the accept after it.
  assign last_word = (wc_inc == len);

  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    word_done = 1'b0;
    ready_nxt = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt = LEN_HI;
          load_go   = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_rx > LIMIT)      state_nxt = ERROR;
          else if (len_rx == '0)   state_nxt = CHECK;
          else                     state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept && byte_cnt == 2'd3) begin
          word_done = 1'b1;
          if (last_word) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (accept) state_nxt = (bus.in_data == xor_acc) ? DONE : ERROR;
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      LEN_HI, LEN_LO, DATA, CHECK: ready_nxt = 1'b1;
      default:                     ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_hold       <= 1'b1;
      bus.wr_en      <= 1'b0;
      bus.wr_address <= '0;
      word_count     <= '0;
      word_reg       <= '0;
      len_hi         <= '0;
      len            <= '0;
      xor_acc        <= '0;
      byte_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      bus.in_ready <= ready_nxt;
      busy         <= ready_nxt;
      done         <= (state_nxt == DONE);
      error        <= (state_nxt == ERROR);
      cpu_hold     <= (state_nxt != DONE);
      bus.wr_en    <= word_done;

      // Address and count advance on the edge that ends each write pulse;
      // the address wraps naturally, the count is one bit wider and does not.
      if (bus.wr_en) begin
        bus.wr_address <= bus.wr_address + {{(ADDR_W-1){1'b0}}, 1'b1};
        word_count     <= wc_inc;
      end

      if (load_go) begin
        bus.wr_address <= '0;
        word_count     <= '0;
        xor_acc        <= '0;
        byte_cnt       <= '0;
      end

      if (accept) begin
        case (state)
          LEN_HI: begin
            len_hi  <= bus.in_data;
            xor_acc <= xor_acc ^ bus.in_data;
          end
          LEN_LO: begin
            len     <= len_rx[ADDR_W:0];
            xor_acc <= xor_acc ^ bus.in_data;
          end
          DATA: begin
            word_reg <= {word_reg[23:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
            xor_acc  <= xor_acc ^ bus.in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// A frame is built as a byte queue; the expected writes and final status are
// derived from the frame bytes alone (length, words, XOR), and compared with
// what a write monitor observes on the imem port.
module tb_imem_loader;
  localparam int ADDR_W = 12;
  localparam int LIMIT  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            cpu_hold, busy, done, error;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         dbl_pulse = 0;
  logic       wr_en_d = 1'b0;
  wr_t        got_q[$];
  logic [7:0] frame[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clock) begin
    wr_t w;
    if (bus.wr_en) begin
      w.addr = bus.wr_address;
      w.data = bus.wr_data;
      got_q.push_back(w);
      if (wr_en_d) dbl_pulse++;
    end
    wr_en_d = bus.wr_en;
  end

  task automatic rst_chk(input string tag);
    chk({tag, "_rdy"},   bus.in_ready,   0);
    chk({tag, "_wen"},   bus.wr_en,      0);
    chk({tag, "_waddr"}, bus.wr_address, 0);
    chk({tag, "_wdata"}, bus.wr_data,    0);
    chk({tag, "_hold"},  cpu_hold,       1);
    chk({tag, "_busy"},  busy,           0);
    chk({tag, "_done"},  done,           0);
    chk({tag, "_err"},   error,          0);
    chk({tag, "_wcnt"},  word_count,     0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Offer one byte, optionally after random idle cycles; returns one step
  // after the edge that transferred it. start may be held high meanwhile.
  task automatic send_byte(input logic [7:0] b, input bit gappy, input bit pulse_start);
    int t = 0;
    bit ok = 0;
    for (int g = 0; g < 4 && gappy && $urandom_range(0, 2) != 0; g++) begin
      bus.in_valid = 1'b0;
      start = pulse_start;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    start        = pulse_start;
    while (!ok && t < 64) begin
      @(negedge clock);
      ok = bus.in_ready;
      @(posedge clock); #1;
      t++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] x;
    frame.delete();
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    if (n <= LIMIT) begin
      for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
      x = 8'h00;
      foreach (frame[i]) x ^= frame[i];
      frame.push_back(bad ? ~x : x);
    end
  endtask

  task automatic build_nominal(input logic [7:0] ck);
    logic [7:0] b [11];
    b = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
    b[10] = ck;
    frame.delete();
    foreach (b[i]) frame.push_back(b[i]);
  endtask

  // Reference: expected writes and status straight from the frame rules.
  task automatic run_frame(input string tag, input bit gappy, input int mid_start_at);
    int         n, nsend;
    bit         ovf, ok;
    logic [7:0] x;
    wr_t        exp_q[$];
    wr_t        w;

    n   = int'({frame[0], frame[1]});
    ovf = (n > LIMIT);
    nsend = ovf ? 2 : frame.size();
    x = 8'h00;
    for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
    ok = !ovf && (frame[frame.size() - 1] == x);
    if (!ovf)
      for (int i = 0; i < n; i++) begin
        w.addr = ADDR_W'(i % LIMIT);
        w.data = {frame[2 + 4 * i], frame[3 + 4 * i], frame[4 + 4 * i], frame[5 + 4 * i]};
        exp_q.push_back(w);
      end

    got_q.delete();
    do_start();
    for (int i = 0; i < nsend; i++) send_byte(frame[i], gappy, i == mid_start_at);
    @(negedge clock);   // one cycle after the final accepting edge

    chk({tag, "_done"},  done,         ok);
    chk({tag, "_err"},   error,        !ok);
    chk({tag, "_hold"},  cpu_hold,     !ok);
    chk({tag, "_rdy"},   bus.in_ready, 0);
    chk({tag, "_busy"},  busy,         0);
    chk({tag, "_wcnt"},  word_count,   ovf ? 0 : n);
    chk({tag, "_waddr"}, bus.wr_address, ovf ? 0 : n % LIMIT);
    chk({tag, "_nwr"},   got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    @(posedge clock); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12 rst_chk("por");
    #8 reset = 1'b1;
    @(posedge clock); #1;

    // Nominal frame, with fixed expectations as well as the model.
    build_nominal(8'h20);
    run_frame("nom", 0, -1);
    chk("nom_w0", got_q.size() > 0 ? got_q[0].data : 32'h0, 32'hDEADBEEF);
    chk("nom_w1", got_q.size() > 1 ? got_q[1].data : 32'h0, 32'h01234567);

    // Bad checksum, then a clean reload.
    build_nominal(8'h21);
    run_frame("badck", 0, -1);
    build_nominal(8'h20);
    run_frame("reload", 0, -1);

    // Empty image and length overflow.
    build(0, 0);
    run_frame("empty", 0, -1);
    build(LIMIT + 1, 0);
    run_frame("ovf", 0, -1);

    // Backpressure with a start pulse held across a DATA byte.
    build_nominal(8'h20);
    run_frame("bp", 1, 5);

    // Reset in the middle of DATA, asynchronous to the clock.
    build_nominal(8'h20);
    do_start();
    for (int i = 0; i < 7; i++) send_byte(frame[i], 0, 0);
    #2 reset = 1'b0;
    #1 rst_chk("midrst");
    @(posedge clock); #3 reset = 1'b1;
    @(posedge clock); #1;
    run_frame("postrst", 0, -1);

    // Random frames: lengths, data, corruption and stalls all random.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(LIMIT + 1, 65535))
                                      : int'($urandom_range(0, 9));
      build(n, $urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", k), $urandom_range(0, 1) == 1, -1);
    end

    // Largest legal image: address wraps to 0, count reaches the limit.
    build(LIMIT, 0);
    run_frame("full", 0, -1);

    chk("dbl_pulse", dbl_pulse, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
